// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the fetch unit and its neighbours: FSM encoding, reset PC
// and the instruction field positions also used by the NPC and control blocks.
package instr_fetch_unit_pkg;

    localparam int unsigned PC_W    = 30;
    localparam int unsigned INSTR_W = 32;

    localparam logic [PC_W-1:0] DEF_RESET_PC = 30'h0000_0C00;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FETCH  = 2'd1,
        ST_VALID  = 2'd2,
        ST_HALTED = 2'd3
    } state_t;

    // Instruction field positions (MIPS-style encoding)
    localparam int unsigned OP_MSB     = 31;
    localparam int unsigned OP_LSB     = 26;
    localparam int unsigned RS_MSB     = 25;
    localparam int unsigned RS_LSB     = 21;
    localparam int unsigned RT_MSB     = 20;
    localparam int unsigned RT_LSB     = 16;
    localparam int unsigned RD_MSB     = 15;
    localparam int unsigned RD_LSB     = 11;
    localparam int unsigned SHAMT_MSB  = 10;
    localparam int unsigned SHAMT_LSB  = 6;
    localparam int unsigned FUNC_MSB   = 5;
    localparam int unsigned FUNC_LSB   = 0;
    localparam int unsigned IMM_MSB    = 15;
    localparam int unsigned IMM_LSB    = 0;
    localparam int unsigned TARGET_MSB = 25;
    localparam int unsigned TARGET_LSB = 0;

    localparam int unsigned OP_W     = OP_MSB - OP_LSB + 1;
    localparam int unsigned REG_W    = RS_MSB - RS_LSB + 1;
    localparam int unsigned FUNC_W   = FUNC_MSB - FUNC_LSB + 1;
    localparam int unsigned IMM_W    = IMM_MSB - IMM_LSB + 1;
    localparam int unsigned TARGET_W = TARGET_MSB - TARGET_LSB + 1;

endpackage

// File: rtl/instr_fetch_unit_field_split.sv
// Combinational slicer from an instruction word to its decode fields.
module instr_field_split
    import instr_fetch_unit_pkg::*;
(
    input  logic [INSTR_W-1:0]  instr,
    output logic [OP_W-1:0]     op,
    output logic [REG_W-1:0]    rs,
    output logic [REG_W-1:0]    rt,
    output logic [REG_W-1:0]    rd,
    output logic [REG_W-1:0]    shamt,
    output logic [FUNC_W-1:0]   func,
    output logic [IMM_W-1:0]    imm16,
    output logic [TARGET_W-1:0] target
);

    assign op     = instr[OP_MSB:OP_LSB];
    assign rs     = instr[RS_MSB:RS_LSB];
    assign rt     = instr[RT_MSB:RT_LSB];
    assign rd     = instr[RD_MSB:RD_LSB];
    assign shamt  = instr[SHAMT_MSB:SHAMT_LSB];
    assign func   = instr[FUNC_MSB:FUNC_LSB];
    assign imm16  = instr[IMM_MSB:IMM_LSB];
    assign target = instr[TARGET_MSB:TARGET_LSB];

endmodule

// File: rtl/instr_fetch_unit.sv
// Architectural PC holder: fetches one instruction per executed instruction over
// a req/ack handshake and loads the NPC result when the core advances.
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = DEF_RESET_PC,
    parameter int unsigned     CNT_W    = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [PC_W-1:0]     npc_in,
    input  logic                advance,
    input  logic                halt,
    output logic                imem_req,
    output logic [PC_W-1:0]     imem_addr,
    input  logic                imem_ack,
    input  logic [INSTR_W-1:0]  imem_rdata,
    output logic [PC_W-1:0]     pc_out,
    output logic [INSTR_W-1:0]  instr,
    output logic                instr_valid,
    output logic [OP_W-1:0]     op,
    output logic [FUNC_W-1:0]   func,
    output logic [REG_W-1:0]    rs,
    output logic [REG_W-1:0]    rt,
    output logic [REG_W-1:0]    rd,
    output logic [REG_W-1:0]    shamt,
    output logic [IMM_W-1:0]    imm16,
    output logic [TARGET_W-1:0] target,
    output logic                halted,
    output logic [CNT_W-1:0]    retired
);

    state_t state, state_nxt;
    logic   req_nxt, valid_nxt, halted_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   state_nxt = ST_FETCH;
            ST_FETCH:  if (imem_ack) state_nxt = ST_VALID;
            ST_VALID:  if (advance)  state_nxt = halt ? ST_HALTED : ST_FETCH;
            ST_HALTED: state_nxt = ST_HALTED;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // Status outputs are decoded from the next state so the flops line up with the state register
    always_comb begin
        req_nxt    = 1'b0;
        valid_nxt  = 1'b0;
        halted_nxt = 1'b0;
        case (state_nxt)
            ST_FETCH:  req_nxt    = 1'b1;
            ST_VALID:  valid_nxt  = 1'b1;
            ST_HALTED: halted_nxt = 1'b1;
            default:   ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            imem_req    <= 1'b0;
            instr_valid <= 1'b0;
            halted      <= 1'b0;
            pc_out      <= RESET_PC;
            instr       <= '0;
            retired     <= '0;
        end else begin
            imem_req    <= req_nxt;
            instr_valid <= valid_nxt;
            halted      <= halted_nxt;
            if (state == ST_FETCH && imem_ack) begin
                instr <= imem_rdata;
            end
            // npc_in is taken verbatim; any PC wrap is the NPC block's job
            if (state == ST_VALID && advance) begin
                pc_out  <= npc_in;
                retired <= retired + CNT_W'(1);
            end
        end
    end

    assign imem_addr = pc_out;

    instr_field_split u_field_split (
        .instr  (instr),
        .op     (op),
        .rs     (rs),
        .rt     (rt),
        .rd     (rd),
        .shamt  (shamt),
        .func   (func),
        .imm16  (imm16),
        .target (target)
    );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with an instruction scoreboard.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [29:0] npc_in;
    logic        advance, halt;
    logic        imem_req;
    logic [29:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [29:0] pc_out;
    logic [31:0] instr;
    logic        instr_valid;
    logic [5:0]  op, func;
    logic [4:0]  rs, rt, rd, shamt;
    logic [15:0] imm16;
    logic [25:0] target;
    logic        halted;
    logic [31:0] retired;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    instr_fetch_unit dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .npc_in     (npc_in),
        .advance    (advance),
        .halt       (halt),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .pc_out     (pc_out),
        .instr      (instr),
        .instr_valid(instr_valid),
        .op         (op),
        .func       (func),
        .rs         (rs),
        .rt         (rt),
        .rd         (rd),
        .shamt      (shamt),
        .imm16      (imm16),
        .target     (target),
        .halted     (halted),
        .retired    (retired)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Bounded wait for instr_valid, then compare against the oldest expected word
    task automatic pop_and_check(input string tag);
        logic [31:0] exp_w;
        for (int i = 0; i < 50 && instr_valid !== 1'b1; i++) step();
        chk({tag, "_valid"}, 64'(instr_valid), 64'(1));
        if (exp_q.size() == 0) begin
            chk({tag, "_sb_empty"}, 64'(exp_q.size()), 64'(1));
        end else begin
            exp_w = exp_q.pop_front();
            chk({tag, "_instr"}, 64'(instr), 64'(exp_w));
        end
    endtask

    initial begin
        rst_n = 1'b0; npc_in = '0; advance = 1'b0; halt = 1'b0;
        imem_ack = 1'b0; imem_rdata = '0;
        repeat (3) step();

        // Reset state
        chk("rst_pc", 64'(pc_out), 64'(30'hC00));
        chk("rst_instr", 64'(instr), 64'(0));
        chk("rst_valid", 64'(instr_valid), 64'(0));
        chk("rst_req", 64'(imem_req), 64'(0));
        chk("rst_halted", 64'(halted), 64'(0));
        chk("rst_retired", 64'(retired), 64'(0));

        // 1: ack tied high, zero-wait fetch
        imem_ack = 1'b1; imem_rdata = 32'h2001_0005;
        exp_q.push_back(32'h2001_0005);
        rst_n = 1'b1;
        step();
        chk("t1_req", 64'(imem_req), 64'(1));
        chk("t1_addr", 64'(imem_addr), 64'(30'hC00));
        chk("t1_valid_early", 64'(instr_valid), 64'(0));
        step();
        pop_and_check("t1");
        chk("t1_req_drop", 64'(imem_req), 64'(0));
        imem_ack = 1'b0;

        // 3: advance from VALID loads npc_in and counts
        npc_in = 30'h0000_0C05; advance = 1'b1;
        step();
        advance = 1'b0;
        chk("t3_pc", 64'(pc_out), 64'(30'hC05));
        chk("t3_retired", 64'(retired), 64'(1));
        chk("t3_valid_drop", 64'(instr_valid), 64'(0));
        chk("t3_req", 64'(imem_req), 64'(1));
        chk("t3_addr", 64'(imem_addr), 64'(30'hC05));

        // 2: three wait cycles then ack; address must stay put
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t2_addr_hold", 64'(imem_addr), 64'(30'hC05));
            chk("t2_req_hold", 64'(imem_req), 64'(1));
        end
        imem_ack = 1'b1; imem_rdata = 32'h1109_FFFE;
        exp_q.push_back(32'h1109_FFFE);
        step();
        imem_ack = 1'b0;
        pop_and_check("t2");
        chk("t2_op", 64'(op), 64'(6'h04));
        chk("t2_rs", 64'(rs), 64'(5'd8));
        chk("t2_rt", 64'(rt), 64'(5'd9));
        chk("t2_rd", 64'(rd), 64'(5'd31));
        chk("t2_shamt", 64'(shamt), 64'(5'd31));
        chk("t2_func", 64'(func), 64'(6'h3E));
        chk("t2_imm16", 64'(imm16), 64'(16'hFFFE));
        chk("t2_target", 64'(target), 64'(26'h109FFFE));

        // 4: ack in VALID ignored
        imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        step();
        imem_ack = 1'b0;
        chk("t4_instr_keep", 64'(instr), 64'(32'h1109_FFFE));
        chk("t4_valid_keep", 64'(instr_valid), 64'(1));
        chk("t4_pc_keep", 64'(pc_out), 64'(30'hC05));
        npc_in = 30'h0000_0C06; advance = 1'b1;
        step();
        advance = 1'b0;
        chk("t4_pc_adv", 64'(pc_out), 64'(30'hC06));
        chk("t4_retired_adv", 64'(retired), 64'(2));
        // advance (with halt) in FETCH ignored
        npc_in = 30'h3FFF_FFFF; advance = 1'b1; halt = 1'b1;
        step();
        advance = 1'b0; halt = 1'b0;
        chk("t4_pc_fetch", 64'(pc_out), 64'(30'hC06));
        chk("t4_retired_fetch", 64'(retired), 64'(2));
        chk("t4_halted_fetch", 64'(halted), 64'(0));
        chk("t4_req_fetch", 64'(imem_req), 64'(1));
        imem_ack = 1'b1; imem_rdata = 32'h8C22_0004;
        exp_q.push_back(32'h8C22_0004);
        step();
        imem_ack = 1'b0;
        pop_and_check("t4");

        // 5: advance with halt -> HALTED, terminal
        npc_in = 30'h3FFF_FFFF; advance = 1'b1; halt = 1'b1;
        step();
        advance = 1'b0; halt = 1'b0;
        chk("t5_pc", 64'(pc_out), 64'(30'h3FFF_FFFF));
        chk("t5_halted", 64'(halted), 64'(1));
        chk("t5_retired", 64'(retired), 64'(3));
        chk("t5_valid", 64'(instr_valid), 64'(0));
        imem_ack = 1'b1; npc_in = 30'h0000_0123;
        for (int i = 0; i < 20; i++) begin
            advance = i[0];
            step();
            chk("t5_req_low", 64'(imem_req), 64'(0));
            chk("t5_halted_hold", 64'(halted), 64'(1));
            chk("t5_pc_hold", 64'(pc_out), 64'(30'h3FFF_FFFF));
        end
        imem_ack = 1'b0; advance = 1'b0;
        chk("t5_retired_hold", 64'(retired), 64'(3));

        // 6: reset mid-FETCH, late ack after release ignored
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        chk("t6_req_pre", 64'(imem_req), 64'(1));
        #2 rst_n = 1'b0;
        #1;
        chk("t6_req_async", 64'(imem_req), 64'(0));
        chk("t6_pc_rst", 64'(pc_out), 64'(30'hC00));
        step();
        imem_ack = 1'b1; imem_rdata = 32'hFFFF_FFFF;
        rst_n = 1'b1;
        step();
        imem_ack = 1'b0;
        chk("t6_instr_zero", 64'(instr), 64'(0));
        chk("t6_valid_zero", 64'(instr_valid), 64'(0));
        chk("t6_pc", 64'(pc_out), 64'(30'hC00));
        chk("t6_retired", 64'(retired), 64'(0));
        chk("t6_req_refetch", 64'(imem_req), 64'(1));
        chk("t6_sb_drained", 64'(exp_q.size()), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
